// File: rtl/lcd_msg_ctrl.sv
// HD44780 8-bit write-only controller: power-up init, then renders a ROWS x COLS
// message from an external character ROM, with E strobe, busy/done and blanking.
module lcd_msg_ctrl #(
    parameter int NUM_MSGS = 4,
    parameter int COLS     = 16,
    parameter int ROWS     = 2,
    parameter int TICK_DIV = 100000,
    parameter int PWR_WAIT = 20,
    localparam int MW = $clog2(NUM_MSGS),
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    input  logic [MW-1:0]       msg_sel,
    input  logic                refresh_i,
    output logic [MW+RW+CW-1:0] char_addr,
    input  logic [7:0]          char_data,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic                lcd_e,
    output logic [7:0]          lcd_db,
    output logic                busy_o,
    output logic                done_o
);

    localparam int SCW  = $clog2(TICK_DIV);
    localparam int CNTW = (PWR_WAIT > 4) ? $clog2(PWR_WAIT) : 2;

    typedef enum logic [3:0] {PWR_W, INIT, IDLE, CLR, ADDR, CHAR, OFF, OFF_I, ON} state_t;

    state_t          state_q, state_d, idle_nx;
    logic [SCW-1:0]  sc_q, sc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [7:0]      db_q, db_d;
    logic [MW-1:0]   shown_msg_q, shown_msg_d;
    logic            last_q, last_d, act_q, act_d, rs_q, rs_d, e_q, e_d;
    logic            shown_valid_q, shown_valid_d, pend_q, pend_d;
    logic            tick, idle_eval, render_req, done_c;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] slot_cmd(input state_t s);
        case (s)
            CLR:     return 8'h01;
            OFF:     return 8'h08;
            default: return 8'h0C;
        endcase
    endfunction

    assign tick       = (sc_q == SCW'(TICK_DIV - 1));
    assign render_req = !shown_valid_q || (msg_sel != shown_msg_q) || pend_q || refresh_i;

    // act_q marks a write slot in progress; CLR/OFF/ON entered mid-slot wait for the next boundary.
    always_comb begin
        state_d       = state_q;
        sc_d          = tick ? '0 : sc_q + 1'b1;
        cnt_d         = cnt_q;
        row_d         = row_q;
        col_d         = col_q;
        last_d        = last_q;
        act_d         = act_q;
        rs_d          = rs_q;
        db_d          = db_q;
        shown_msg_d   = shown_msg_q;
        shown_valid_d = shown_valid_q;
        pend_d        = pend_q | refresh_i;
        idle_eval     = 1'b0;
        idle_nx       = IDLE;
        done_c        = 1'b0;

        case (state_q)
            PWR_W: if (tick) begin
                if (cnt_q == CNTW'(PWR_WAIT - 1)) begin
                    state_d = INIT;
                    cnt_d   = '0;
                    act_d   = 1'b1;
                    rs_d    = 1'b0;
                    db_d    = init_cmd(2'd0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            INIT: if (tick) begin
                if (cnt_q[1:0] == 2'd3) begin
                    idle_eval = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    db_d  = init_cmd(cnt_q[1:0] + 2'd1);
                end
            end
            IDLE: idle_eval = 1'b1;
            CLR, OFF, ON: if (tick) begin
                if (!act_q) begin
                    act_d = 1'b1;
                    rs_d  = 1'b0;
                    db_d  = slot_cmd(state_q);
                end else if (state_q == CLR) begin
                    state_d = ADDR;
                    row_d   = '0;
                    col_d   = '0;
                    last_d  = 1'b0;
                    db_d    = 8'h80;
                end else if (state_q == OFF) begin
                    state_d = OFF_I;
                    act_d   = 1'b0;
                end else begin
                    idle_eval = 1'b1;
                end
            end
            ADDR: if (tick) begin
                state_d = CHAR;
                rs_d    = 1'b1;
                db_d    = char_data;
                if (col_q == CW'(COLS - 1)) last_d = 1'b1;
                else                        col_d  = col_q + 1'b1;
            end
            CHAR: if (tick) begin
                if (!last_q) begin
                    rs_d = 1'b1;
                    db_d = char_data;
                    if (col_q == CW'(COLS - 1)) last_d = 1'b1;
                    else                        col_d  = col_q + 1'b1;
                end else if (row_q != RW'(ROWS - 1)) begin
                    state_d = ADDR;
                    row_d   = row_q + 1'b1;
                    col_d   = '0;
                    last_d  = 1'b0;
                    rs_d    = 1'b0;
                    db_d    = 8'hC0;
                end else begin
                    done_c    = 1'b1;
                    idle_eval = 1'b1;
                end
            end
            OFF_I: if (en_i) begin
                state_d = ON;
                act_d   = tick;
                if (tick) begin
                    rs_d = 1'b0;
                    db_d = slot_cmd(ON);
                end
            end
            default: state_d = PWR_W;
        endcase

        // Shared IDLE decision, also taken directly at slot ends so frames chain without a gap.
        if (idle_eval) begin
            if (!en_i) begin
                idle_nx       = OFF;
                shown_valid_d = 1'b0;
            end else if (render_req) begin
                idle_nx       = CLR;
                shown_msg_d   = msg_sel;
                shown_valid_d = 1'b1;
                pend_d        = 1'b0;
            end
            state_d = idle_nx;
            act_d   = tick && (idle_nx != IDLE);
            if (tick && (idle_nx != IDLE)) begin
                rs_d = 1'b0;
                db_d = slot_cmd(idle_nx);
            end
        end

        e_d = act_d && (sc_d != '0) && (sc_d <= SCW'(TICK_DIV / 2));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= PWR_W;
            sc_q          <= '0;
            cnt_q         <= '0;
            row_q         <= '0;
            col_q         <= '0;
            last_q        <= 1'b0;
            act_q         <= 1'b0;
            rs_q          <= 1'b0;
            e_q           <= 1'b0;
            db_q          <= 8'h00;
            shown_msg_q   <= '0;
            shown_valid_q <= 1'b0;
            pend_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sc_q          <= sc_d;
            cnt_q         <= cnt_d;
            row_q         <= row_d;
            col_q         <= col_d;
            last_q        <= last_d;
            act_q         <= act_d;
            rs_q          <= rs_d;
            e_q           <= e_d;
            db_q          <= db_d;
            shown_msg_q   <= shown_msg_d;
            shown_valid_q <= shown_valid_d;
            pend_q        <= pend_d;
        end
    end

    assign char_addr = {shown_msg_q, row_q, col_q};
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = e_q;
    assign lcd_db    = db_q;
    assign done_o    = done_c;
    assign busy_o    = !(((state_q == IDLE) || (state_q == OFF_I)) && (state_d == state_q));

endmodule
